// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared raster-timing types, standard mode presets and the
//               helper functions used for elaboration-time width checks.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

  // Timing of one axis: visible region followed by front porch, sync, back porch.
  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  typedef struct packed {
    axis_timing_t h;
    axis_timing_t v;
  } mode_t;

  localparam mode_t MODE_640x480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
  localparam mode_t MODE_800x600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

  // Number of counter states in one period of an axis.
  function automatic int unsigned total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  // True when a cw-bit counter can represent every value 0..n-1.
  function automatic bit fits(input int unsigned n, input int unsigned cw);
    return (64'(1) << cw) >= 64'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Raster timing bundle between the generator (master) and a
//               pixel sink (slave). The sink owns the run enable.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
  parameter int unsigned CW = 11
);
  logic          en;
  logic          hsync;
  logic          vsync;
  logic          de;
  logic [CW-1:0] hpos;
  logic [CW-1:0] vpos;
  logic          pix_stb;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en,
    output hsync, vsync, de, hpos, vpos, pix_stb, line_start, frame_start
  );

  modport slave (
    output en,
    input  hsync, vsync, de, hpos, vpos, pix_stb, line_start, frame_start
  );
endinterface
`default_nettype wire

// File: rtl/video_axis_cnt.sv
`default_nettype none
// ============================================================================
// Module      : video_axis_cnt
// Description : One raster axis: position counter with wrap/carry-out and
//               combinational decode of the active and sync regions.
// Revision    : 1.0 - initial release
// ============================================================================
module video_axis_cnt
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE = 8,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 3,
  parameter int unsigned BP     = 1,
  parameter int unsigned CW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          wrap_o,
  output logic          first_o,
  output logic          active_o,
  output logic          sync_o
);

  // One extra bit so a sync region ending exactly at 2**CW still decodes.
  localparam int unsigned XW    = CW + 1;
  localparam int unsigned TOTAL = total(axis_timing_t'{ACTIVE, FP, SYNC, BP});
  localparam logic [XW-1:0] C_LAST     = XW'(TOTAL - 1);
  localparam logic [XW-1:0] C_ACT_END  = XW'(ACTIVE);
  localparam logic [XW-1:0] C_SYNC_BEG = XW'(ACTIVE + FP);
  localparam logic [XW-1:0] C_SYNC_END = XW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] cnt_x;

  assign cnt_x = {1'b0, cnt_q};

  // Next count: clear has priority, then wrap at the last state, else advance.
  always_comb begin
    wrap_o = inc_i && (cnt_x == C_LAST);
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Position register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign first_o  = (cnt_q == '0);
  assign active_o = (cnt_x < C_ACT_END);
  assign sync_o   = (cnt_x >= C_SYNC_BEG) && (cnt_x < C_SYNC_END);

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator. Produces registered
//               hsync/vsync/de, pixel coordinates and pixel/line/frame strobes
//               with programmable sync polarity and pixel-clock prescale.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = MODE_640x480_60.h.active,
  parameter int unsigned H_FP     = MODE_640x480_60.h.fp,
  parameter int unsigned H_SYNC   = MODE_640x480_60.h.sync,
  parameter int unsigned H_BP     = MODE_640x480_60.h.bp,
  parameter int unsigned V_ACTIVE = MODE_640x480_60.v.active,
  parameter int unsigned V_FP     = MODE_640x480_60.v.fp,
  parameter int unsigned V_SYNC   = MODE_640x480_60.v.sync,
  parameter int unsigned V_BP     = MODE_640x480_60.v.bp,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned PIX_DIV  = 1,
  parameter int unsigned CW       = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = total(axis_timing_t'{H_ACTIVE, H_FP, H_SYNC, H_BP});
  localparam int unsigned V_TOTAL = total(axis_timing_t'{V_ACTIVE, V_FP, V_SYNC, V_BP});
  localparam int unsigned PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(PIX_DIV - 1);

  if (PIX_DIV < 1 || !fits(H_TOTAL, CW) || !fits(V_TOTAL, CW)) begin : g_param_err
    $error("video_timing_gen: PIX_DIV must be >= 1 and CW must hold H_TOTAL-1 and V_TOTAL-1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [CW-1:0] hcnt, vcnt;
  logic          h_wrap, h_first, h_active, h_sync;
  logic          v_wrap_unused, v_first, v_active, v_sync;

  logic          hsync_q, vsync_q, de_q;
  logic [CW-1:0] hpos_q, vpos_q;
  logic          pix_stb_q, line_start_q, frame_start_q;

  // Pixel prescaler: counts only while enabled, rewinds when disabled.
  always_comb begin
    tick    = vid.en && (presc_q == C_PRESC_LAST);
    presc_d = presc_q + PW'(1);
    if (!vid.en || tick) begin
      presc_d = '0;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  video_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!vid.en),
    .inc_i    (tick),
    .cnt_o    (hcnt),
    .wrap_o   (h_wrap),
    .first_o  (h_first),
    .active_o (h_active),
    .sync_o   (h_sync)
  );

  // Lines advance on the carry out of the horizontal counter.
  video_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!vid.en),
    .inc_i    (tick && h_wrap),
    .cnt_o    (vcnt),
    .wrap_o   (v_wrap_unused),
    .first_o  (v_first),
    .active_o (v_active),
    .sync_o   (v_sync)
  );

  // Output registers: sample the counters on each tick, hold between ticks, idle when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (!vid.en) begin
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      pix_stb_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pix_stb_q     <= tick;
      line_start_q  <= tick && h_first;
      frame_start_q <= tick && h_first && v_first;
      if (tick) begin
        hsync_q <= h_sync ? H_POL : ~H_POL;
        vsync_q <= v_sync ? V_POL : ~V_POL;
        de_q    <= h_active && v_active;
        hpos_q  <= hcnt;
        vpos_q  <= vcnt;
      end
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.de          = de_q;
  assign vid.hpos        = hpos_q;
  assign vid.vpos        = vpos_q;
  assign vid.pix_stb     = pix_stb_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Directed self-checking bench for video_timing_gen using a
//               small 14x8 mode (both polarities, PIX_DIV 1 and 3) and the
//               default 640x480 preset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  // Packed view: [26]hsync [25]vsync [24]de [23]line_start [22]frame_start [21:11]hpos [10:0]vpos
  localparam logic [26:0] C_IDLE_LO = 27'h600_0000;
  localparam logic [26:0] C_IDLE_HI = 27'h000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CW(11)) vif0 ();
  video_timing_gen_if #(.CW(11)) vif1 ();
  video_timing_gen_if #(.CW(11)) vif2 ();
  video_timing_gen_if #(.CW(11)) vif3 ();

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(1), .CW(11)
  ) u_dut0 (.clk(clk), .rst_n(rst_n), .vid(vif0));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CW(11)
  ) u_dut1 (.clk(clk), .rst_n(rst_n), .vid(vif1));

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(3), .CW(11)
  ) u_dut2 (.clk(clk), .rst_n(rst_n), .vid(vif2));

  video_timing_gen u_dut3 (.clk(clk), .rst_n(rst_n), .vid(vif3));

  logic [26:0] obs0, obs1, obs2;
  assign obs0 = {vif0.hsync, vif0.vsync, vif0.de, vif0.line_start, vif0.frame_start, vif0.hpos, vif0.vpos};
  assign obs1 = {vif1.hsync, vif1.vsync, vif1.de, vif1.line_start, vif1.frame_start, vif1.hpos, vif1.vpos};
  assign obs2 = {vif2.hsync, vif2.vsync, vif2.de, vif2.line_start, vif2.frame_start, vif2.hpos, vif2.vpos};

  // Expected outputs of the small mode for pixel index p counted from frame start.
  function automatic logic [26:0] model(input int p, input bit pol);
    int q, h, v;
    bit hs_a, vs_a;
    q    = p % 112;
    h    = q % 14;
    v    = q / 14;
    hs_a = (h >= 10) && (h < 13);
    vs_a = (v >= 5) && (v < 7);
    return {(pol ? hs_a : !hs_a), (pol ? vs_a : !vs_a), ((h < 8) && (v < 4)),
            (h == 0), (q == 0), 11'(h), 11'(v)};
  endfunction

  // Hold reset for two clocks and release on a falling edge; the next rising edge is clk 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if (obs0 !== C_IDLE_LO) $display("FAIL reset_dut0 got=%h exp=%h", obs0, C_IDLE_LO);
    else n_pass++;
    n_chk++;
    if (obs1 !== C_IDLE_HI) $display("FAIL reset_dut1_pol got=%h exp=%h", obs1, C_IDLE_HI);
    else n_pass++;
    n_chk++;
    if (obs2 !== C_IDLE_LO) $display("FAIL reset_dut2 got=%h exp=%h", obs2, C_IDLE_LO);
    else n_pass++;
    n_chk++;
    if ({vif0.pix_stb, vif1.pix_stb, vif2.pix_stb, vif3.pix_stb} !== 4'b0000)
      $display("FAIL reset_pix_stb got=%b exp=0000",
               {vif0.pix_stb, vif1.pix_stb, vif2.pix_stb, vif3.pix_stb});
    else n_pass++;
    n_chk++;
    if ({vif3.hsync, vif3.vsync, vif3.de} !== 3'b110)
      $display("FAIL reset_dut3 got=%b exp=110", {vif3.hsync, vif3.vsync, vif3.de});
    else n_pass++;
  endtask

  task automatic test_small_frame();
    int fs_cnt, ls_cnt, de_cnt;
    logic [26:0] exp;
    fs_cnt = 0; ls_cnt = 0; de_cnt = 0;
    do_reset();
    for (int k = 1; k <= 224; k++) begin
      @(negedge clk);
      exp = model(k - 1, 1'b0);
      n_chk++;
      if ({vif0.pix_stb, obs0} !== {1'b1, exp})
        $display("FAIL small_frame k=%0d got=%h exp=%h", k, {vif0.pix_stb, obs0}, {1'b1, exp});
      else n_pass++;
      fs_cnt += int'(vif0.frame_start);
      ls_cnt += int'(vif0.line_start);
      de_cnt += int'(vif0.de);
    end
    n_chk++;
    if (fs_cnt !== 2) $display("FAIL small_frame_starts got=%0d exp=2", fs_cnt);
    else n_pass++;
    n_chk++;
    if (ls_cnt !== 16) $display("FAIL small_line_starts got=%0d exp=16", ls_cnt);
    else n_pass++;
    n_chk++;
    if (de_cnt !== 64) $display("FAIL small_de_count got=%0d exp=64", de_cnt);
    else n_pass++;
  endtask

  task automatic test_sync_polarity();
    int hs_hi, vs_hi;
    logic [26:0] exp;
    hs_hi = 0; vs_hi = 0;
    do_reset();
    for (int k = 1; k <= 112; k++) begin
      @(negedge clk);
      exp = model(k - 1, 1'b1);
      n_chk++;
      if ({vif1.pix_stb, obs1} !== {1'b1, exp})
        $display("FAIL polarity k=%0d got=%h exp=%h", k, {vif1.pix_stb, obs1}, {1'b1, exp});
      else n_pass++;
      hs_hi += int'(vif1.hsync);
      vs_hi += int'(vif1.vsync);
    end
    n_chk++;
    if (hs_hi !== 24) $display("FAIL polarity_hsync_high got=%0d exp=24", hs_hi);
    else n_pass++;
    n_chk++;
    if (vs_hi !== 28) $display("FAIL polarity_vsync_high got=%0d exp=28", vs_hi);
    else n_pass++;
  endtask

  task automatic test_prescale();
    int fs_first, fs_second;
    logic [26:0] exp;
    logic stb_exp;
    fs_first = -1; fs_second = -1;
    do_reset();
    for (int k = 1; k <= 345; k++) begin
      @(negedge clk);
      stb_exp = (k % 3 == 0);
      if (k < 3) begin
        exp = C_IDLE_LO;
      end else begin
        exp = model(k / 3 - 1, 1'b0);
        if (!stb_exp) exp[23:22] = 2'b00;
      end
      n_chk++;
      if ({vif2.pix_stb, obs2} !== {stb_exp, exp})
        $display("FAIL prescale k=%0d got=%h exp=%h", k, {vif2.pix_stb, obs2}, {stb_exp, exp});
      else n_pass++;
      if (vif2.frame_start === 1'b1) begin
        if (fs_first < 0) fs_first = k;
        else if (fs_second < 0) fs_second = k;
      end
    end
    n_chk++;
    if (fs_first !== 3 || fs_second !== 339)
      $display("FAIL prescale_frame_period got=%0d,%0d exp=3,339", fs_first, fs_second);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    logic [26:0] exp;
    do_reset();
    repeat (34) @(negedge clk);
    exp = model(33, 1'b0);
    n_chk++;
    if (obs0 !== exp) $display("FAIL en_drop_position got=%h exp=%h", obs0, exp);
    else n_pass++;
    vif0.en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_chk++;
      if ({vif0.pix_stb, obs0} !== {1'b0, C_IDLE_LO})
        $display("FAIL en_drop_blank j=%0d got=%h exp=%h", j, {vif0.pix_stb, obs0}, {1'b0, C_IDLE_LO});
      else n_pass++;
    end
    vif0.en = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      exp = model(j, 1'b0);
      n_chk++;
      if ({vif0.pix_stb, obs0} !== {1'b1, exp})
        $display("FAIL en_restart j=%0d got=%h exp=%h", j, {vif0.pix_stb, obs0}, {1'b1, exp});
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [26:0] exp;
    do_reset();
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({vif0.pix_stb, obs0} !== {1'b0, C_IDLE_LO})
      $display("FAIL async_reset got=%h exp=%h", {vif0.pix_stb, obs0}, {1'b0, C_IDLE_LO});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      exp = model(k - 1, 1'b0);
      n_chk++;
      if ({vif0.pix_stb, obs0} !== {1'b1, exp})
        $display("FAIL async_restart k=%0d got=%h exp=%h", k, {vif0.pix_stb, obs0}, {1'b1, exp});
      else n_pass++;
    end
  endtask

  task automatic test_vga_default();
    int de_cnt, hs_lo, vs_lo, first_lo;
    de_cnt = 0; hs_lo = 0; vs_lo = 0; first_lo = -1;
    do_reset();
    for (int k = 1; k <= 801; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_chk++;
        if ({vif3.frame_start, vif3.line_start, vif3.hpos, vif3.vpos} !== 24'hC0_0000)
          $display("FAIL vga_first_pixel got=%b%b h=%0d v=%0d exp=11 h=0 v=0",
                   vif3.frame_start, vif3.line_start, vif3.hpos, vif3.vpos);
        else n_pass++;
      end
      if (k <= 800) begin
        de_cnt += int'(vif3.de);
        vs_lo  += int'(!vif3.vsync);
        if (!vif3.hsync) begin
          hs_lo++;
          if (first_lo < 0) first_lo = int'(vif3.hpos);
        end
      end else begin
        n_chk++;
        if ({vif3.frame_start, vif3.line_start, vif3.hpos, vif3.vpos} !== 24'h40_0001)
          $display("FAIL vga_line_period got=%b%b h=%0d v=%0d exp=01 h=0 v=1",
                   vif3.frame_start, vif3.line_start, vif3.hpos, vif3.vpos);
        else n_pass++;
      end
    end
    n_chk++;
    if (de_cnt !== 640) $display("FAIL vga_de_per_line got=%0d exp=640", de_cnt);
    else n_pass++;
    n_chk++;
    if (hs_lo !== 96 || first_lo !== 656)
      $display("FAIL vga_hsync got=%0d@%0d exp=96@656", hs_lo, first_lo);
    else n_pass++;
    n_chk++;
    if (vs_lo !== 0) $display("FAIL vga_vsync_line0 got=%0d exp=0", vs_lo);
    else n_pass++;
  endtask

  initial begin
    vif0.en = 1'b1;
    vif1.en = 1'b1;
    vif2.en = 1'b1;
    vif3.en = 1'b1;
    test_reset();
    test_small_frame();
    test_sync_polarity();
    test_prescale();
    test_enable_drop();
    test_async_reset();
    test_vga_default();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
